// File: rtl/nibble_pair_combiner_if.sv
// Handshake bundle between a nibble-sum producer and the pair combiner.
// The master modport belongs to the upstream/downstream side, and the slave modport belongs to the combiner.
interface nibble_pair_combiner_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_ctrl;
  logic [4:0] in_q;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_sum;

  modport master (
    output in_valid, in_ctrl, in_q, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_ctrl, in_q, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/nibble_pair_combiner.sv
// Pairs low/high nibble-sum beats into a 10-bit result (hi*16 + lo) and queues it in a 2-entry FIFO.
// The block flags out-of-order tags in a sticky seq_err and counts every pushed result.
module nibble_pair_combiner (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_pair_combiner_if.slave       bus,
  input  logic                        clr_err,
  output logic                        seq_err,
  output logic [7:0]                  pair_count
);

  localparam logic [0:0] WAIT_LO = 1'b0;
  localparam logic [0:0] WAIT_HI = 1'b1;

  logic [0:0] r_state;
  logic [4:0] r_lo;
  logic [9:0] r_head;
  logic [9:0] r_tail;
  logic [1:0] r_count;
  logic       r_seq_err;
  logic [7:0] r_pair_count;

  logic       w_in_ready;
  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic       w_err;
  logic [9:0] w_sum;

  // In WAIT_HI, the ready signal is gated only by FIFO occupancy, so it never depends on out_ready.
  assign w_in_ready = rst_n && ((r_state == WAIT_LO) || (r_count != 2'd2));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_push     = w_accept && (r_state == WAIT_HI) && bus.in_ctrl;
  assign w_pop      = (r_count != 2'd0) && bus.out_ready;
  assign w_err      = w_accept && ((r_state == WAIT_LO) == bus.in_ctrl);
  assign w_sum      = {1'b0, bus.in_q, 4'b0000} + {5'b00000, r_lo};

  // NOTE: sequential state uses non-blocking assignments, so every block sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_LO;
      r_lo    <= '0;
    end else if (w_accept) begin
      if (r_state == WAIT_LO) begin
        if (!bus.in_ctrl) begin
          r_lo    <= bus.in_q;
          r_state <= WAIT_HI;
        end
      end else begin
        if (bus.in_ctrl) r_state <= WAIT_LO;
        else             r_lo    <= bus.in_q;
      end
    end
  end

  // NOTE: the FIFO storage is reset because out_sum must read 0 immediately after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= w_sum;
          else                 r_tail <= w_sum;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        // Push can only happen below full and pop only when non-empty, so the FIFO holds exactly one entry here.
        2'b11: r_head <= w_sum;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_err    <= 1'b0;
      r_pair_count <= '0;
    end else begin
      if (w_err)        r_seq_err <= 1'b1;
      else if (clr_err) r_seq_err <= 1'b0;
      if (w_push) r_pair_count <= r_pair_count + 8'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_sum   = r_head;
  assign seq_err       = r_seq_err;
  assign pair_count    = r_pair_count;

endmodule

// File: tb/tb_nibble_pair_combiner.sv
// Directed bench for nibble_pair_combiner: pairing, back-pressure, tag errors, reset and counter wrap.
// Inputs are driven 1 time unit after each rising edge, and outputs are checked at that same point.
module tb_nibble_pair_combiner;

  logic       clk;
  logic       rst_n;
  logic       clr_err;
  logic       seq_err;
  logic [7:0] pair_count;
  int         n_vec;
  int         n_miss;

  nibble_pair_combiner_if bus ();

  nibble_pair_combiner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_err    (clr_err),
    .seq_err    (seq_err),
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic ctrl, input logic [4:0] q);
    bus.in_valid = 1'b1;
    bus.in_ctrl  = ctrl;
    bus.in_q     = q;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec         = 0;
    n_miss        = 0;
    rst_n         = 1'b0;
    clr_err       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = 1'b0;
    bus.in_q      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_sum", 32'(bus.out_sum), 0);
    check("rst_seq_err", 32'(seq_err), 0);
    check("rst_pair_count", 32'(pair_count), 0);
    #6 rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Basic pair: 22*16 + 23 = 375
    bus.out_ready = 1'b1;
    beat(1'b0, 5'd23);
    check("basic_no_early_valid", 32'(bus.out_valid), 0);
    beat(1'b1, 5'd22);
    check("basic_out_valid", 32'(bus.out_valid), 1);
    check("basic_out_sum", 32'(bus.out_sum), 375);
    check("basic_pair_count", 32'(pair_count), 1);
    tick();
    check("basic_valid_one_cycle", 32'(bus.out_valid), 0);

    // Back-pressure: A=2*16+1=33, B=4*16+3=67, C=6*16+5=101
    bus.out_ready = 1'b0;
    beat(1'b0, 5'd1);
    beat(1'b1, 5'd2);
    beat(1'b0, 5'd3);
    beat(1'b1, 5'd4);
    beat(1'b0, 5'd5);
    check("bp_full_in_ready", 32'(bus.in_ready), 0);
    check("bp_head_a", 32'(bus.out_sum), 33);
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 1'b1;
    bus.in_q     = 5'd6;
    tick();
    check("bp_stall_in_ready", 32'(bus.in_ready), 0);
    check("bp_stall_pair_count", 32'(pair_count), 3);
    bus.out_ready = 1'b1;
    tick();
    check("bp_pop_a_head_b", 32'(bus.out_sum), 67);
    check("bp_pop_a_in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_pushpop_head_c", 32'(bus.out_sum), 101);
    check("bp_pushpop_valid", 32'(bus.out_valid), 1);
    check("bp_pair_count", 32'(pair_count), 4);
    tick();
    check("bp_drained", 32'(bus.out_valid), 0);

    // High beat while waiting for low beat
    beat(1'b1, 5'd5);
    check("hi_in_lo_seq_err", 32'(seq_err), 1);
    check("hi_in_lo_no_push", 32'(bus.out_valid), 0);
    check("hi_in_lo_pair_count", 32'(pair_count), 4);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err_clears", 32'(seq_err), 0);

    // Low beat overwritten: 1*16 + 7 = 23
    beat(1'b0, 5'd3);
    beat(1'b0, 5'd7);
    check("lo_lo_seq_err", 32'(seq_err), 1);
    beat(1'b1, 5'd1);
    check("lo_lo_out_sum", 32'(bus.out_sum), 23);
    check("lo_lo_pair_count", 32'(pair_count), 5);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("lo_lo_cleared", 32'(seq_err), 0);

    // Mid-pair reset followed by maximum result 31*16+31=527
    beat(1'b0, 5'd9);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 0);
    check("midrst_pair_count", 32'(pair_count), 0);
    check("midrst_out_sum", 32'(bus.out_sum), 0);
    #2 rst_n = 1'b1;
    tick();
    beat(1'b0, 5'd31);
    check("max_first_is_low", 32'(bus.out_valid), 0);
    beat(1'b1, 5'd31);
    check("max_out_sum", 32'(bus.out_sum), 527);
    check("max_pair_count", 32'(pair_count), 1);
    check("max_no_seq_err", 32'(seq_err), 0);

    // Counter wrap: 254 more pairs reach 255, then one more wraps to 0
    for (int i = 0; i < 254; i++) begin
      beat(1'b0, i[4:0]);
      beat(1'b1, 5'(i + 3));
    end
    check("wrap_pre_255", 32'(pair_count), 255);
    beat(1'b0, 5'd17);
    beat(1'b1, 5'd30);
    check("wrap_out_sum", 32'(bus.out_sum), 497);
    check("wrap_pair_count", 32'(pair_count), 0);

    // Error set and clr_err in the same cycle: the set wins
    clr_err = 1'b1;
    beat(1'b1, 5'd0);
    clr_err = 1'b0;
    check("set_wins_seq_err", 32'(seq_err), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("set_wins_cleared", 32'(seq_err), 0);

    // Idle inputs with a bogus tag must not change state; 1*16 + 4 = 20
    beat(1'b0, 5'd4);
    bus.in_ctrl = 1'b0;
    bus.in_q    = 5'd31;
    repeat (3) tick();
    check("idle_no_err", 32'(seq_err), 0);
    check("idle_pair_count", 32'(pair_count), 0);
    beat(1'b1, 5'd1);
    check("idle_out_sum", 32'(bus.out_sum), 20);
    check("idle_after_pair_count", 32'(pair_count), 1);
    check("idle_after_seq_err", 32'(seq_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
